// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// The credit helper decides whether one more read may be issued this cycle.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  // Slots already claimed after this cycle's pop; a read is allowed while
  // that leaves room for the word it will return.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [OCC_W:0] used;
    used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    return (used < (OCC_W+1)'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry, in-order holding buffer between the FIFO read port and the
// output stream. Entry 0 is always the head; same-cycle push and pop is legal.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             eff_pop;

  assign eff_pop = pop && (occ_q != '0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, eff_pop})
      2'b10: begin
        occ_d = occ_q + 1'b1;
        if (occ_q == '0) begin
          ent0_d = push_data;
        end else begin
          ent1_d = push_data;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 1'b1;
        ent0_d = ent1_q;
      end
      2'b11: begin
        // Occupancy unchanged: the head leaves and the new word queues behind.
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = ent0_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !eff_pop && (occ_q == OCC_W'(BUF_DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (occ_q == '0)));

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the synchronous FIFO: issues credit-limited reads
// and presents the returned words on a valid/ready stream.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_cs,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy
);

  // Stream handshake: a word transfers on every rising edge where m_valid and
  // m_ready are both high; m_data holds steady while m_valid && !m_ready.

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             rd_en;

  assign m_valid = (occ != '0);
  assign m_data  = head_data;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = FLUSH;
      end
      FLUSH: begin
        if (enable) begin
          state_d = RUN;
        end else if (!inflight_q && (occ == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_cs = 1'b0;
    busy    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      RUN: begin
        fifo_cs = 1'b1;
        busy    = 1'b1;
        rd_en   = !fifo_empty && credit_ok(occ, inflight_q, pop);
      end
      FLUSH: begin
        fifo_cs = 1'b1;
        busy    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fifo_rd_en = rd_en;

  // A read issued this cycle returns its word next cycle.
  assign inflight_d = rd_en;
  assign rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;

  fifo_reader_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  a_rd_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader against a behavioural one-cycle-latency FIFO.
// Each scenario task drives stimulus and checks its own expectations.
module tb_fifo_reader;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_cs;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [CNT_W-1:0] rd_count;
  logic             busy;

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .rd_count   (rd_count),
    .busy       (busy)
  );

  // FIFO model: written by the driver task, read by rd_en at the clock edge
  logic [WIDTH-1:0] fmem [0:1023];
  logic [31:0]      wr_ptr = 0;
  logic [31:0]      rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: records accepted words and read activity (no checking here)
  logic [WIDTH-1:0] got_mem [0:255];
  logic [31:0]      got_wr     = 0;
  logic [31:0]      rd_issued  = 0;
  logic [31:0]      empty_viol = 0;

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      got_mem[got_wr[7:0]] <= m_data;
      got_wr <= got_wr + 1;
    end
    if (fifo_rd_en) rd_issued <= rd_issued + 1;
    if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
  end

  logic [WIDTH-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic fifo_push(input logic [WIDTH-1:0] w, input bit track);
    fmem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
    if (track) exp_q.push_back(w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fifo_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %b exp 0", fifo_cs); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", m_data); end
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", rd_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] r0, g0, idx;
    logic [WIDTH-1:0] e;
    r0 = rd_issued;
    g0 = got_wr;
    fifo_push(32'd1, 1);
    fifo_push(32'd100, 1);
    fifo_push(32'd10000, 1);
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 40 && (got_wr - g0) < 3; i++) @(negedge clk);
    checks++; if ((got_wr - g0) !== 32'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", got_wr - g0); end
    for (int k = 0; k < 3; k++) begin
      idx = g0 + k;
      e = exp_q.pop_front();
      checks++; if (got_mem[idx[7:0]] !== e) begin errors++; $display("FAIL basic_word%0d got %0d exp %0d", k, got_mem[idx[7:0]], e); end
    end
    repeat (5) @(negedge clk);
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL basic_rd_count got %0d exp 3", rd_count); end
    checks++; if ((rd_issued - r0) !== 32'd3) begin errors++; $display("FAIL basic_reads got %0d exp 3", rd_issued - r0); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL basic_rd_en_empty got %b exp 0", fifo_rd_en); end
    checks++; if (empty_viol !== 32'd0) begin errors++; $display("FAIL basic_read_on_empty got %0d exp 0", empty_viol); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
  endtask

  task automatic test_burst();
    logic [31:0] g0, idx;
    logic [WIDTH-1:0] e;
    int run, max_run, first_rd, first_v;
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_flush_idle got %b exp 0", busy); end
    checks++; if (fifo_cs !== 1'b0) begin errors++; $display("FAIL burst_idle_cs got %b exp 0", fifo_cs); end
    for (int k = 0; k < 128; k++) fifo_push($urandom, 1);
    g0 = got_wr;
    run = 0; max_run = 0; first_rd = -1; first_v = -1;
    enable = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if ((got_wr - g0) >= 128) break;
      if (fifo_rd_en) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_rd < 0) first_rd = c;
      end else begin
        run = 0;
      end
      if (m_valid && first_v < 0) first_v = c;
      @(negedge clk);
    end
    checks++; if (max_run !== 128) begin errors++; $display("FAIL burst_rd_run got %0d exp 128", max_run); end
    checks++; if ((first_v - first_rd) !== 2) begin errors++; $display("FAIL burst_latency got %0d exp 2", first_v - first_rd); end
    checks++; if ((got_wr - g0) !== 32'd128) begin errors++; $display("FAIL burst_count got %0d exp 128", got_wr - g0); end
    for (int k = 0; k < 128; k++) begin
      idx = g0 + k;
      e = exp_q.pop_front();
      checks++; if (got_mem[idx[7:0]] !== e) begin errors++; $display("FAIL burst_word%0d got %h exp %h", k, got_mem[idx[7:0]], e); end
    end
    @(negedge clk);
    checks++; if (rd_count !== 16'd131) begin errors++; $display("FAIL burst_rd_count got %0d exp 131", rd_count); end
  endtask

  task automatic test_stall();
    logic [31:0] r0, g0, idx;
    logic [WIDTH-1:0] e, head;
    int bad, vcnt;
    m_ready = 1'b0;
    r0 = rd_issued;
    g0 = got_wr;
    for (int k = 0; k < 10; k++) fifo_push(32'hA000_0000 + k, 1);
    head = exp_q[0];
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && (m_data !== head)) bad++;
    end
    checks++; if ((rd_issued - r0) !== 32'd2) begin errors++; $display("FAIL stall_reads got %0d exp 2", rd_issued - r0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_data_stable got %0d changes exp 0", bad); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", m_valid); end
    checks++; if (m_data !== head) begin errors++; $display("FAIL stall_head got %h exp %h", m_data, head); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got %b exp 0", fifo_rd_en); end
    m_ready = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stall_reassert got %b exp 1", fifo_rd_en); end
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if ((got_wr - g0) >= 10) break;
      if (m_valid) vcnt++;
      @(negedge clk);
    end
    checks++; if (vcnt !== 10) begin errors++; $display("FAIL stall_no_gaps got %0d valid cycles exp 10", vcnt); end
    checks++; if ((got_wr - g0) !== 32'd10) begin errors++; $display("FAIL stall_count got %0d exp 10", got_wr - g0); end
    for (int k = 0; k < 10; k++) begin
      idx = g0 + k;
      e = exp_q.pop_front();
      checks++; if (got_mem[idx[7:0]] !== e) begin errors++; $display("FAIL stall_word%0d got %h exp %h", k, got_mem[idx[7:0]], e); end
    end
    @(negedge clk);
    checks++; if (rd_count !== 16'd141) begin errors++; $display("FAIL stall_rd_count got %0d exp 141", rd_count); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] r0, g0, idx;
    logic [WIDTH-1:0] e;
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    fifo_push(32'h0000_1111, 1);
    fifo_push(32'h0000_2222, 1);
    fifo_push(32'h0000_3333, 1);
    fifo_push(32'h0000_4444, 1);
    r0 = rd_issued;
    g0 = got_wr;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL drop_first_read got %b exp 1", fifo_rd_en); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL drop_no_read got %b exp 0", fifo_rd_en); end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", busy); end
    checks++; if ((got_wr - g0) !== 32'd2) begin errors++; $display("FAIL drop_delivered got %0d exp 2", got_wr - g0); end
    for (int k = 0; k < 2; k++) begin
      idx = g0 + k;
      e = exp_q.pop_front();
      checks++; if (got_mem[idx[7:0]] !== e) begin errors++; $display("FAIL drop_word%0d got %h exp %h", k, got_mem[idx[7:0]], e); end
    end
    checks++; if ((wr_ptr - rd_ptr) !== 32'd2) begin errors++; $display("FAIL drop_fifo_left got %0d exp 2", wr_ptr - rd_ptr); end
    checks++; if ((rd_issued - r0) !== 32'd2) begin errors++; $display("FAIL drop_reads got %0d exp 2", rd_issued - r0); end
    checks++; if (rd_count !== 16'd143) begin errors++; $display("FAIL drop_rd_count got %0d exp 143", rd_count); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r0;
    m_ready = 1'b0;
    r0 = rd_issued;
    enable = 1'b1;
    for (int i = 0; i < 20 && (rd_issued - r0) < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (m_data !== 32'h0000_3333) begin errors++; $display("FAIL areset_pre_head got %h exp 00003333", m_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", m_valid); end
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL areset_count got %0d exp 0", rd_count); end
    checks++; if (fifo_cs !== 1'b0) begin errors++; $display("FAIL areset_cs got %b exp 0", fifo_cs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL areset_data got %h exp 0", m_data); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_wrap();
    logic [31:0] g0, pushed, idx;
    logic [WIDTH-1:0] e;
    m_ready = 1'b1;
    enable  = 1'b1;
    g0 = got_wr;
    pushed = 0;
    for (int c = 0; c < 70000; c++) begin
      if ((got_wr - g0) >= 32'd65535) break;
      if (pushed < 32'd65535 && (wr_ptr - rd_ptr) < 4) begin
        fifo_push(pushed, 0);
        pushed = pushed + 1;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++; if ((got_wr - g0) !== 32'd65535) begin errors++; $display("FAIL wrap_run got %0d exp 65535", got_wr - g0); end
    checks++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %0d exp 65535", rd_count); end
    fifo_push(32'hCAFE_F00D, 1);
    for (int i = 0; i < 20 && (got_wr - g0) < 32'd65536; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", rd_count); end
    idx = g0 + 32'd65535;
    e = exp_q.pop_front();
    checks++; if (got_mem[idx[7:0]] !== e) begin errors++; $display("FAIL wrap_word got %h exp %h", got_mem[idx[7:0]], e); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b exp 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_stall();
    test_enable_drop();
    test_async_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's synchronous FIFO (`des`: `cs`/`rd_en`/`data_out`/`empty`). It pops words from the FIFO whenever downstream has room and presents them on a valid/ready stream, absorbing the FIFO's one-cycle read latency with a 2-entry output buffer. It is the consumer counterpart to the FIFO's write port, and it sits between the FIFO and any downstream datapath that can apply backpressure.

## Interface
- `WIDTH`, 32: data word width; must match the FIFO.
- `CNT_W`, 16: width of the accepted-word counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; 1 = drain FIFO, 0 = stop issuing reads and flush.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  WIDTH  FIFO `data_out`.
- `fifo_cs`  out  1  FIFO chip select.
- `fifo_rd_en`  out  1  FIFO read enable.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WIDTH  output word.
- `m_ready`  in  1  downstream accept.
- `rd_count`  out  CNT_W  words accepted downstream; wraps modulo 2^CNT_W.
- `busy`  out  1  high when state is not IDLE.

## Operation
- States:
  - IDLE: `fifo_cs`=0. Goes to RUN when `enable`=1.
  - RUN: reads are issued. Goes to FLUSH when `enable`=0.
  - FLUSH: no new reads. Goes to IDLE once in-flight=0 and buffer occupancy=0. If `enable` rises in FLUSH, return to RUN.
- `fifo_cs` = 1 in RUN and FLUSH.
- `fifo_rd_en` is combinational. It is 1 iff state=RUN, `fifo_empty`=0, and `occ + inflight - pop < 2`, where:
  - `occ` = buffer occupancy, 0..2;
  - `inflight` = 1 if `fifo_rd_en` was high in the previous cycle;
  - `pop` = `m_valid && m_ready` this cycle.
- `fifo_rd_en` is never asserted while `fifo_empty`=1.
- Buffer:
  - 2-entry FIFO-ordered holding register.
  - Captures `fifo_data` in the cycle after a read was issued.
  - Push and pop in the same cycle are legal.
  - Overflow is impossible by the credit rule; an assertion checks it.
- `m_valid` = (occ > 0). `m_data` = head entry, held stable while `m_valid` && !`m_ready`.
- `rd_count` increments by 1 on each `m_valid && m_ready`, and wraps from 2^CNT_W-1 to 0.
- Reset values: state IDLE, `fifo_cs`=0, `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, `busy`=0, occ=0, inflight=0.

## Timing
- FIFO contract: `rd_en` sampled at edge E; the popped word appears on `fifo_data` after E and is stable for the following cycle.
- Latency: `fifo_rd_en` high in cycle k → word is on `m_data` with `m_valid`=1 in cycle k+2.
- With `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` stays high every cycle: one word per cycle.
- When `m_ready`=0, at most 2 further reads complete after the stall begins, then `fifo_rd_en` drops.
  - It reasserts in the same cycle as the first pop.
- `enable` falling in cycle k: no `fifo_rd_en` from cycle k+1 onward. An in-flight word is still captured and delivered. No word is dropped or duplicated.
- FIFO going empty mid-burst: `fifo_rd_en` deasserts in the same cycle `fifo_empty` rises, and resumes the cycle it falls.
- Asynchronous reset mid-operation:
  - all outputs take their reset values immediately;
  - buffered and in-flight words are discarded;
  - a pop already committed to the FIFO is lost. This is accepted behaviour.

## Structure
- Package `fifo_reader_pkg`: `state_t` enum {IDLE, RUN, FLUSH}; localparam `BUF_DEPTH = 2`.
- Sub-module `fifo_reader_skid`: the 2-entry output buffer.
  - Ports: `push`, `push_data`, `pop`, `occ`, `head_data`.
  - Asynchronous active-low reset.
- Top level holds the FSM, credit logic, in-flight flag and counter.

## Test plan
- Reset, then write 1, 100, 10000 into the FIFO; `enable`=1, `m_ready`=1 → `m_data` sequence is 1, 100, 10000, then `rd_count`=3 and `fifo_rd_en` stays 0 once `fifo_empty`=1.
- Fill FIFO with 128 random words, `m_ready`=1 → 128 consecutive cycles of `fifo_rd_en`=1, output matches a reference queue in order, `rd_count`=128.
- 10 words queued, `m_ready`=0 for 20 cycles → exactly 2 reads issued and `m_data` stable; on `m_ready`=1, all 10 words are delivered in order with no gaps after the first.
- Drop `enable` the cycle after a read is issued → that word is still delivered, `busy` falls once the buffer is empty, and the FIFO retains the remaining words.
- Assert `rst_n`=0 while `occ`=2 → `m_valid`=0, `rd_count`=0 and `fifo_cs`=0 immediately, before the next clock edge.
- Preload `rd_count` to 65535 (via a forced run of accepted words) → the next accepted word wraps `rd_count` to 0.
